seg_scan_ctrl: RTL and testbench

SEG_SCAN_CTRL -- requirements
Module: seg_scan_ctrl

---
 rtl/seg_scan_pkg.sv | 24 ++
 rtl/seg_digit_decode.sv | 26 ++
 rtl/seg_scan_ctrl.sv | 150 +++++++++++++++
 tb/tb_seg_scan_ctrl.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/seg_scan_pkg.sv
// Shared types and segment patterns for the multiplexed 7-segment scan controller.
// Patterns are gfedcba, bit 0 = segment a, active-high.
package seg_scan_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    BLANK = 2'd2
  } scan_state_e;

  localparam logic [6:0] SEG_BLANK = 7'b0000000;

  localparam logic [6:0] SEG_0 = 7'b0111111;
  localparam logic [6:0] SEG_1 = 7'b0000110;
  localparam logic [6:0] SEG_2 = 7'b1011011;
  localparam logic [6:0] SEG_3 = 7'b1001111;
  localparam logic [6:0] SEG_4 = 7'b1100110;
  localparam logic [6:0] SEG_5 = 7'b1101101;
  localparam logic [6:0] SEG_6 = 7'b1111101;
  localparam logic [6:0] SEG_7 = 7'b0000111;
  localparam logic [6:0] SEG_8 = 7'b1111111;
  localparam logic [6:0] SEG_9 = 7'b1101111;

endpackage

// File: rtl/seg_digit_decode.sv
// Combinational BCD nibble to gfedcba decoder; non-BCD codes 10..15 render blank.
module seg_digit_decode
  import seg_scan_pkg::*;
(
  input  logic [3:0] nibble_i,
  output logic [6:0] pattern_o
);

  always_comb begin
    pattern_o = SEG_BLANK;
    unique case (nibble_i)
      4'd0:    pattern_o = SEG_0;
      4'd1:    pattern_o = SEG_1;
      4'd2:    pattern_o = SEG_2;
      4'd3:    pattern_o = SEG_3;
      4'd4:    pattern_o = SEG_4;
      4'd5:    pattern_o = SEG_5;
      4'd6:    pattern_o = SEG_6;
      4'd7:    pattern_o = SEG_7;
      4'd8:    pattern_o = SEG_8;
      4'd9:    pattern_o = SEG_9;
      default: pattern_o = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/seg_scan_ctrl.sv
// Multiplexed 7-segment scan controller with frame-coherent double-buffered display value.
// Optional leading-zero suppression is enabled by defining SEG_SCAN_LZ_SUPPRESS_EN.
module seg_scan_ctrl
  import seg_scan_pkg::*;
#(
  parameter int unsigned DIGITS    = 4,
  parameter int unsigned SCAN_DIV  = 1000,
  parameter int unsigned BLANK_CYC = 50
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  load_valid,
  input  logic [4*DIGITS-1:0]   load_data,
  output logic                  load_ready,
  output logic [6:0]            seg,
  output logic [DIGITS-1:0]     an,
  output logic                  frame_start
);

  localparam int unsigned CW        = $clog2(SCAN_DIV);
  localparam int unsigned IW        = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int unsigned DRIVE_CYC = SCAN_DIV - BLANK_CYC;

  scan_state_e         state_q, state_d;
  logic [IW-1:0]       idx_q, idx_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [4*DIGITS-1:0] pend_q;
  logic [4*DIGITS-1:0] active_q;
  logic                ready_q;
  logic                start_d;
  logic [3:0]          cur_nibble;
  logic [6:0]          dec_pattern;

  // While scanning is disabled the controller never blocks a load.
  assign load_ready = ready_q | ~en;

  // The slot counter runs 0..SCAN_DIV-1 across the whole slot; DRIVE covers the low part.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    if (!en) begin
      state_d = IDLE;
      idx_d   = '0;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          state_d = DRIVE;
          idx_d   = '0;
          cnt_d   = '0;
        end
        DRIVE: begin
          cnt_d = cnt_q + CW'(1);
          if (cnt_q == CW'(DRIVE_CYC - 1)) begin
            state_d = BLANK;
          end
        end
        BLANK: begin
          if (cnt_q == CW'(SCAN_DIV - 1)) begin
            state_d = DRIVE;
            cnt_d   = '0;
            idx_d   = (idx_q == IW'(DIGITS - 1)) ? '0 : idx_q + IW'(1);
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        default: begin
          state_d = IDLE;
          idx_d   = '0;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // Edge on which DRIVE of digit 0 begins: the frame boundary.
  assign start_d = (state_d == DRIVE) && (state_q != DRIVE) && (idx_d == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      cnt_q    <= '0;
      pend_q   <= '0;
      active_q <= '0;
      ready_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      if (!en) begin
        // Pending mirrors active so the first frame after enable keeps this value.
        if (load_valid) begin
          active_q <= load_data;
          pend_q   <= load_data;
        end
        ready_q <= 1'b1;
      end else begin
        if (start_d) begin
          active_q <= pend_q;
        end
        if (load_valid && ready_q) begin
          pend_q  <= load_data;
          ready_q <= 1'b0;
        end else if (start_d) begin
          ready_q <= 1'b1;
        end
      end
    end
  end

  assign cur_nibble = active_q[idx_q*4 +: 4];

  seg_digit_decode u_decode (
    .nibble_i  (cur_nibble),
    .pattern_o (dec_pattern)
  );

`ifdef SEG_SCAN_LZ_SUPPRESS_EN
  // lz_blank[i] is set when nibble i and every nibble above it are zero; digit 0 never blanks.
  logic [DIGITS-1:0] lz_blank;
  always_comb begin
    logic run;
    run      = 1'b1;
    lz_blank = '0;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      run         = run && (active_q[i*4 +: 4] == 4'd0);
      lz_blank[i] = run;
    end
  end
`endif

  always_comb begin
    an          = '0;
    seg         = SEG_BLANK;
    frame_start = 1'b0;
    if (state_q == DRIVE) begin
      an          = DIGITS'(1) << idx_q;
`ifdef SEG_SCAN_LZ_SUPPRESS_EN
      seg         = lz_blank[idx_q] ? SEG_BLANK : dec_pattern;
`else
      seg         = dec_pattern;
`endif
      frame_start = (idx_q == '0) && (cnt_q == '0);
    end
  end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Self-checking bench for seg_scan_ctrl: directed scenarios plus random traffic vs a timeline model.
module tb_seg_scan_ctrl;

  localparam int DIGITS    = 4;
  localparam int SCAN_DIV  = 8;
  localparam int BLANK_CYC = 2;
  localparam int DRV       = SCAN_DIV - BLANK_CYC;
  localparam int FRAME     = DIGITS * SCAN_DIV;

  logic                clk;
  logic                rst;
  logic                en;
  logic                load_valid;
  logic [4*DIGITS-1:0] load_data;
  logic                load_ready;
  logic [6:0]          seg;
  logic [DIGITS-1:0]   an;
  logic                frame_start;

  seg_scan_ctrl #(
    .DIGITS    (DIGITS),
    .SCAN_DIV  (SCAN_DIV),
    .BLANK_CYC (BLANK_CYC)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .en          (en),
    .load_valid  (load_valid),
    .load_data   (load_data),
    .load_ready  (load_ready),
    .seg         (seg),
    .an          (an),
    .frame_start (frame_start)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_total = 0;
  int n_bad   = 0;

  // Reference model: scanning flag, cycle index since scan start, buffered values.
  bit                  m_scan;
  int                  m_t;
  logic [4*DIGITS-1:0] m_active;
  logic [4*DIGITS-1:0] m_pend;
  bit                  m_rdy;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [6:0] pat(input logic [3:0] n);
    case (n)
      4'd0: return 7'b0111111;
      4'd1: return 7'b0000110;
      4'd2: return 7'b1011011;
      4'd3: return 7'b1001111;
      4'd4: return 7'b1100110;
      4'd5: return 7'b1101101;
      4'd6: return 7'b1111101;
      4'd7: return 7'b0000111;
      4'd8: return 7'b1111111;
      4'd9: return 7'b1101111;
      default: return 7'b0000000;
    endcase
  endfunction

  task automatic model_edge(input logic r, input logic e, input logic v,
                            input logic [4*DIGITS-1:0] d);
    bit accept;
    bit fb;
    if (r) begin
      m_scan = 0; m_t = 0; m_active = '0; m_pend = '0; m_rdy = 1;
    end else if (!e) begin
      m_scan = 0; m_t = 0;
      if (v) begin m_active = d; m_pend = d; end
      m_rdy = 1;
    end else begin
      accept = v && m_rdy;
      if (!m_scan) begin m_scan = 1; m_t = 0; end
      else m_t = m_t + 1;
      fb = (m_t % FRAME) == 0;
      if (fb) m_active = m_pend;
      if (accept) begin m_pend = d; m_rdy = 0; end
      else if (fb) m_rdy = 1;
    end
  endtask

  task automatic compare(input logic e);
    logic [DIGITS-1:0] x_an;
    logic [6:0]        x_seg;
    logic              x_fs;
    int p, dg, w;
    x_an = '0; x_seg = '0; x_fs = 1'b0;
    if (m_scan) begin
      p  = m_t % FRAME;
      dg = p / SCAN_DIV;
      w  = p % SCAN_DIV;
      if (w < DRV) begin
        x_an  = DIGITS'(1) << dg;
        x_seg = pat(m_active[dg*4 +: 4]);
`ifdef SEG_SCAN_LZ_SUPPRESS_EN
        if (dg != 0 && (m_active >> (4*dg)) == 0) x_seg = '0;
`endif
        x_fs = (p == 0);
      end
    end
    check("an", 32'(an), 32'(x_an));
    check("seg", 32'(seg), 32'(x_seg));
    check("frame_start", 32'(frame_start), 32'(x_fs));
    check("load_ready", 32'(load_ready), 32'(!e || m_rdy));
  endtask

  task automatic tick(input logic r, input logic e, input logic v,
                      input logic [4*DIGITS-1:0] d);
    rst = r; en = e; load_valid = v; load_data = d;
    @(posedge clk);
    model_edge(r, e, v, d);
    #1;
    compare(e);
  endtask

  task automatic run(input int n, input logic e);
    for (int i = 0; i < n; i++) tick(1'b0, e, 1'b0, '0);
  endtask

  function automatic logic [4*DIGITS-1:0] rand_val();
    logic [4*DIGITS-1:0] v;
    for (int i = 0; i < DIGITS; i++) begin
      v[i*4 +: 4] = ($urandom_range(0, 1) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
    end
    return v;
  endfunction

  initial begin
    rst = 1'b1; en = 1'b0; load_valid = 1'b0; load_data = '0;
    m_scan = 0; m_t = 0; m_active = '0; m_pend = '0; m_rdy = 1;

    // Reset with scan disabled
    tick(1'b1, 1'b0, 1'b0, '0);
    tick(1'b1, 1'b0, 1'b0, '0);
    run(2, 1'b0);

    // Scan order with 0x1234 loaded while disabled
    tick(1'b0, 1'b0, 1'b1, 16'h1234);
    run(FRAME + 10, 1'b1);

    // Mid-frame update, repeated offers while blocked, visible only at next frame
    tick(1'b0, 1'b1, 1'b1, 16'h5678);
    for (int i = 0; i < 6; i++) tick(1'b0, 1'b1, 1'b1, 16'h9999);
    run(2 * FRAME, 1'b1);

    // Invalid nibbles with an still asserted
    run(2, 1'b0);
    tick(1'b0, 1'b0, 1'b1, 16'h00AF);
    run(FRAME + 4, 1'b1);

    // Leading-zero patterns
    run(1, 1'b0);
    tick(1'b0, 1'b0, 1'b1, 16'h0007);
    run(FRAME, 1'b1);
    run(1, 1'b0);
    tick(1'b0, 1'b0, 1'b1, 16'h0000);
    run(FRAME, 1'b1);

    // Abort during digit 2 drive, then resume
    run(1, 1'b0);
    tick(1'b0, 1'b0, 1'b1, 16'h1234);
    run(2 * SCAN_DIV + 3, 1'b1);
    run(3, 1'b0);
    run(FRAME + 2, 1'b1);

    // Reset mid-slot with a load outstanding
    tick(1'b0, 1'b1, 1'b1, 16'h4321);
    run(3, 1'b1);
    tick(1'b1, 1'b1, 1'b1, 16'h8888);
    run(FRAME, 1'b1);

    // Random traffic
    begin
      logic e;
      e = 1'b1;
      for (int i = 0; i < 3000; i++) begin
        if ($urandom_range(0, 99) < 2) e = ~e;
        tick(($urandom_range(0, 999) < 3), e, ($urandom_range(0, 99) < 15), rand_val());
      end
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
